// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: control bit indices,
// default-width payload layout and the {main_v, skid_v} state encoding.
package pipe_pkg;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_RD_W   = 5;
  localparam int unsigned DEF_CTRL_W = 2;

  // Field order is the contract; pipe_stage_buf mirrors it at its own widths.
  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_RD_W-1:0]   rd;
  } stage_payload_t;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// Single payload register with load enable and synchronous clear.
module pipe_entry_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush, bubble-gated
// control and a saturating stall counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned RD_W             = 5,
  parameter int unsigned CTRL_W           = 2,
  parameter bit          ZERO_RD_SUPPRESS = 1'b1,
  parameter int unsigned CNT_W            = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_alu,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
  } payload_t;

  localparam int unsigned PAY_W = CTRL_W + 2 * DATA_W + RD_W;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  payload_t cap_pay, main_d, main_q, skid_q;
  logic     main_load, skid_load, main_from_skid;
  logic     main_v, in_fire, out_fire;

  assign main_v   = state_q[1];
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_v & out_ready;

  always_comb begin
    cap_pay.ctrl = in_ctrl;
    cap_pay.data = in_data;
    cap_pay.alu  = in_alu;
    cap_pay.rd   = in_rd;
    // Writes to x0 are dropped at capture so WB never sees them.
    if (ZERO_RD_SUPPRESS && (in_rd == '0)) begin
      cap_pay.ctrl[CTRL_REGWRITE] = 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d   = StOne;
            main_load = 1'b1;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = StFull;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d        = StOne;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  assign main_d     = main_from_skid ? skid_q : cap_pay;
  assign in_ready_d = (state_d != StFull);

  always_comb begin
    stall_d = stall_q;
    if (main_v && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  pipe_entry_reg #(
    .WIDTH(PAY_W)
  ) u_main (
    .clk  (clk),
    .clr  (!rst_n),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_entry_reg #(
    .WIDTH(PAY_W)
  ) u_skid (
    .clk  (clk),
    .clr  (!rst_n),
    .load (skid_load),
    .d    (cap_pay),
    .q    (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign out_ctrl  = main_q.ctrl & {CTRL_W{main_v}};
  assign out_data  = main_q.data;
  assign out_alu   = main_q.alu;
  assign out_rd    = main_q.rd;
  assign stall_cnt = stall_q;

endmodule
